// File: rtl/comp_divider_pkg.sv
// comp_divider_pkg
// Shared definitions for the sequential restoring divider: the default
// operand width, the controller state type and the iteration counter width.
// No ports (package only).
package comp_divider_pkg;

  // Default operand/result width; the iteration count equals the width.
  localparam int WIDTH_DEF = 32;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter is one bit wider than needed to index WIDTH steps, so it
  // can also represent WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W_DEF = $clog2(WIDTH_DEF) + 1;

endpackage

// File: rtl/comp_divider_step.sv
// comp_divider_step
// One combinational restoring-division step. The partial remainder is
// shifted left with the next dividend bit (the MSB of quo), the divisor is
// trial-subtracted, and the quotient register shifts left, taking the new
// quotient bit as its LSB.
// Ports:
//   rem      in   WIDTH  current partial remainder
//   quo      in   WIDTH  dividend/quotient shift register
//   divisor  in   WIDTH  latched divisor
//   rem_next out  WIDTH  partial remainder after this step
//   quo_next out  WIDTH  shift register after this step
module comp_divider_step
  import comp_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] diff;
  logic           borrow;

  // Working one bit wider keeps the shifted remainder from overflowing.
  // Because the remainder always stays below the divisor (or, for a zero
  // divisor, below 2**WIDTH), the top bit of the difference is a reliable
  // borrow flag, i.e. it is set exactly when rem_shift < divisor.
  assign rem_shift = {rem, quo[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, divisor};
  assign borrow    = diff[WIDTH];

  // Restore on borrow, otherwise keep the difference and record a 1.
  always_comb begin
    rem_next = rem_shift[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!borrow) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/comp_divider.sv
// comp_divider
// Sequential unsigned restoring divider producing one quotient bit per
// clock. Run in IDLE latches the operands; WIDTH steps later Ready rises
// with the quotient and remainder, and stays high until Run is released.
// Optional build macro: COMPDIV_ZERO_BYPASS_EN - a zero divisor skips the
// iterations and finishes one edge after the start.
// Ports:
//   clk           in   1      clock, rising edge active
//   Reset         in   1      asynchronous active-low reset
//   Run           in   1      start request (level)
//   Dividend_in   in   WIDTH  dividend, sampled on start
//   Divisor_in    in   WIDTH  divisor, sampled on start
//   Quotient_out  out  WIDTH  quotient, valid while Ready=1
//   Remainder_out out  WIDTH  remainder, valid while Ready=1
//   Ready         out  1      result valid level
module comp_divider
  import comp_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [WIDTH-1:0] Dividend_in,
  input  logic [WIDTH-1:0] Divisor_in,
  output logic [WIDTH-1:0] Quotient_out,
  output logic [WIDTH-1:0] Remainder_out,
  output logic             Ready
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  comp_divider_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // The quo register starts as the dividend and is shifted into the
  // quotient, so after the last step the registers are the result and
  // they simply hold until the next start or reset.
  assign Quotient_out  = quo;
  assign Remainder_out = rem;

  // Controller: start in IDLE, iterate in BUSY (ignoring Run and the
  // operand inputs), then hold the result in DONE until Run is released
  // so a held Run cannot retrigger an operation.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      count   <= '0;
      Ready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Run) begin
            quo     <= Dividend_in;
            divisor <= Divisor_in;
            rem     <= '0;
            count   <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
`ifdef COMPDIV_ZERO_BYPASS_EN
          // A zero divisor always subtracts nothing, so the full
          // iteration would leave all ones and the dividend; jump there.
          if (divisor == '0) begin
            quo   <= '1;
            rem   <= quo;
            state <= DONE;
            Ready <= 1'b1;
          end else begin
`endif
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count + 1'b1;
            if (count == LAST_STEP) begin
              state <= DONE;
              Ready <= 1'b1;
            end
`ifdef COMPDIV_ZERO_BYPASS_EN
          end
`endif
        end
        DONE: begin
          if (!Run) begin
            state <= IDLE;
            Ready <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          Ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comp_divider.sv
// tb_comp_divider
// Scoreboard bench for comp_divider: each started operation pushes its
// expected quotient, remainder and latency; a monitor pops and compares on
// every rising edge of Ready.
module tb_comp_divider;

  localparam int W = 32;

  logic         clk;
  logic         Reset;
  logic         Run;
  logic [W-1:0] Dividend_in;
  logic [W-1:0] Divisor_in;
  logic [W-1:0] Quotient_out;
  logic [W-1:0] Remainder_out;
  logic         Ready;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
    int           start;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edgeCnt = 0;

  comp_divider #(.WIDTH(W)) dut (
    .clk           (clk),
    .Reset         (Reset),
    .Run           (Run),
    .Dividend_in   (Dividend_in),
    .Divisor_in    (Divisor_in),
    .Quotient_out  (Quotient_out),
    .Remainder_out (Remainder_out),
    .Ready         (Ready)
  );

  // Free-running clock and an edge counter used for latency measurement.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Reference: plain integer division; divide-by-zero gives all ones and
  // the dividend as remainder.
  function automatic exp_t refModel(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = {W{1'b1}};
      e.r = a;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
`ifdef COMPDIV_ZERO_BYPASS_EN
    e.lat = (b == 0) ? 1 : W;
`else
    e.lat = W;
`endif
    e.start = 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h required 0x%h", name, actual, expected);
    end
  endtask

  // Start one operation, optionally scrambling operands during BUSY or
  // dropping Run early, then walk the handshake back to IDLE.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit scramble, input bit dropRun);
    exp_t e;
    bit   got;
    @(negedge clk);
    Run = 1'b1;
    Dividend_in = a;
    Divisor_in = b;
    e = refModel(a, b);
    e.start = edgeCnt + 1;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (Ready) begin
        got = 1'b1;
        break;
      end
      if (scramble) begin
        Dividend_in = $urandom;
        Divisor_in = $urandom;
      end
      if (dropRun && i == 3) Run = 1'b0;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: Ready=%0b required 1 within 60 cycles", Ready);
    end
    if (!dropRun) begin
      repeat (3) @(negedge clk);
      checkOutput("ready_hold", W'(Ready), W'(1));
      Run = 1'b0;
    end
    @(negedge clk);
    checkOutput("ready_drop", W'(Ready), W'(0));
    checkOutput("q_held", Quotient_out, e.q);
    checkOutput("r_held", Remainder_out, e.r);
  endtask

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return W'(1);
      3: return W'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compare the result on each rising edge of Ready.
  initial begin : monitor
    logic prevReady;
    exp_t e;
    prevReady = 1'b0;
    forever begin
      @(negedge clk);
      if (Ready && !prevReady) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ready: Ready=1 required 0 (no operation pending)");
        end else begin
          e = sb.pop_front();
          checkOutput("quotient", Quotient_out, e.q);
          checkOutput("remainder", Remainder_out, e.r);
          checkOutput("latency", W'(edgeCnt - e.start), W'(e.lat));
        end
      end
      prevReady = Ready;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    Reset = 1'b1;
    Run = 1'b0;
    Dividend_in = '0;
    Divisor_in = '0;
    #1 Reset = 1'b0;
    #1;
    checkOutput("reset_ready", W'(Ready), W'(0));
    checkOutput("reset_q", Quotient_out, '0);
    checkOutput("reset_r", Remainder_out, '0);
    @(negedge clk);
    Reset = 1'b1;

    applyStimulus(32'd100, 32'd7, 1'b0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    applyStimulus(32'd5, 32'd9, 1'b0, 1'b0);
    applyStimulus(32'h1234_5678, 32'd0, 1'b0, 1'b0);

    // Abort mid-operation: outputs clear immediately and nothing completes.
    @(negedge clk);
    Run = 1'b1;
    Dividend_in = 32'd1000;
    Divisor_in = 32'd3;
    @(negedge clk);
    Run = 1'b0;
    repeat (10) @(posedge clk);
    #2 Reset = 1'b0;
    #1;
    checkOutput("abort_ready", W'(Ready), W'(0));
    checkOutput("abort_q", Quotient_out, '0);
    checkOutput("abort_r", Remainder_out, '0);
    @(negedge clk);
    Reset = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("abort_no_ready", W'(Ready), W'(0));

    applyStimulus(32'd1000, 32'd3, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'h10, 1'b1, 1'b0);
    applyStimulus(32'd999_999, 32'd1234, 1'b1, 1'b1);

    for (int n = 0; n < 200; n++) begin
      applyStimulus(pickOperand(), pickOperand(),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", W'(sb.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
